// File: rtl/ddram_arb_pkg.sv
// Shared types for the two-port DDRAM arbiter.
// Request bundle carries an absolute 64-bit word address.
package ddram_arb_pkg;
  typedef enum logic [2:0] {
    DRAIN,
    IDLE,
    ISSUE_RD,
    WAIT_RD,
    ISSUE_WR
  } arb_state_t;

  typedef struct packed {
    logic [28:0] waddr;
    logic [2:0]  lane;
    logic [7:0]  data;
    logic        we;
  } ddr_req_t;

  localparam logic [7:0] BURST1 = 8'd1;
endpackage

// File: rtl/ddram_arb_port.sv
// One requester: edge detect, request latch, 1-line read cache,
// ready/dout handshake towards the byte-wide client.
module ddram_arb_port
  import ddram_arb_pkg::*;
#(
  parameter int          AW   = 21,
  parameter logic [28:0] BASE = 29'h0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    din,
  input  logic          rd,
  input  logic          wr,
  input  logic          act,
  input  logic          go,
  input  logic          grant,
  input  logic          done_rd,
  input  logic          done_wr,
  input  logic          inval,
  input  logic [28:0]   inval_waddr,
  input  logic [63:0]   fill,
  output logic          need,
  output ddr_req_t      req,
  output logic          ready,
  output logic [7:0]    dout
);
  logic        rd_q, wr_q, pending, inflight, valid;
  logic [28:0] tag;
  logic [63:0] cline;
  logic        rise, stale, hit;

  assign rise  = (rd | wr) & ~(rd_q | wr_q);
  // a write accepted this very cycle must not be beaten by a stale hit
  assign stale = inval & (inval_waddr == tag);
  assign hit   = valid & ~stale & (tag == req.waddr);
  assign need  = pending & ~inflight & (req.we | ~hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      pending  <= 1'b0;
      inflight <= 1'b0;
      valid    <= 1'b0;
      tag      <= '0;
      cline    <= '0;
      req      <= '0;
      ready    <= 1'b0;
      dout     <= '0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
      if (go)
        ready <= 1'b1;
      if (rise && act && !pending) begin
        pending   <= 1'b1;
        ready     <= 1'b0;
        req.waddr <= BASE + 29'(addr[AW-1:3]);
        req.lane  <= addr[2:0];
        req.data  <= din;
        req.we    <= wr;
      end
      if (grant)
        inflight <= 1'b1;
      if (pending && !inflight && !req.we && hit) begin
        pending <= 1'b0;
        ready   <= 1'b1;
        dout    <= cline[{req.lane, 3'b000} +: 8];
      end
      if (done_wr) begin
        pending  <= 1'b0;
        inflight <= 1'b0;
        ready    <= 1'b1;
      end
      if (done_wr && valid && tag == req.waddr)
        cline[{req.lane, 3'b000} +: 8] <= req.data;
      else if (stale)
        valid <= 1'b0;
      if (done_rd) begin
        pending  <= 1'b0;
        inflight <= 1'b0;
        ready    <= 1'b1;
        valid    <= 1'b1;
        tag      <= req.waddr;
        cline    <= fill;
        dout     <= fill[{req.lane, 3'b000} +: 8];
      end
    end
  end
endmodule

// File: rtl/ddram_arb.sv
// Two byte-wide requesters sharing one 64-bit DDRAM port:
// shared FSM, round-robin grant, cross-port invalidation.
module ddram_arb
  import ddram_arb_pkg::*;
#(
  parameter int          AW_A      = 21,
  parameter int          AW_B      = 25,
  parameter logic [28:0] BASE_A    = 29'h0300000,
  parameter logic [28:0] BASE_B    = 29'h0400000,
  parameter int          DRAIN_CYC = 64
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic [AW_A-1:0] a_addr,
  input  logic [7:0]      a_din,
  output logic [7:0]      a_dout,
  input  logic            a_rd,
  input  logic            a_wr,
  output logic            a_ready,
  input  logic [AW_B-1:0] b_addr,
  input  logic [7:0]      b_din,
  output logic [7:0]      b_dout,
  input  logic            b_rd,
  input  logic            b_wr,
  output logic            b_ready,
  input  logic            DDRAM_BUSY,
  output logic [28:0]     DDRAM_ADDR,
  output logic [7:0]      DDRAM_BURSTCNT,
  output logic            DDRAM_RD,
  output logic            DDRAM_WE,
  output logic [63:0]     DDRAM_DIN,
  output logic [7:0]      DDRAM_BE,
  input  logic [63:0]     DDRAM_DOUT,
  input  logic            DDRAM_DOUT_READY
);
  localparam int CW = $clog2(DRAIN_CYC + 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          last_b, sel_b;
  logic          need_a, need_b, pick_b, start;
  logic          act, go, acc_wr, fill_ok;
  ddr_req_t      req_a, req_b, greq;

  assign act     = (state != DRAIN);
  assign go      = (state == DRAIN) & (cnt == CW'(DRAIN_CYC - 1));
  assign pick_b  = need_b & (~need_a | ~last_b);
  assign start   = (state == IDLE) & (need_a | need_b);
  assign greq    = pick_b ? req_b : req_a;
  assign acc_wr  = (state == ISSUE_WR) & ~DDRAM_BUSY;
  assign fill_ok = (state == WAIT_RD) & DDRAM_DOUT_READY;

  assign DDRAM_BURSTCNT = BURST1;

  ddram_arb_port #(.AW(AW_A), .BASE(BASE_A)) u_a (
    .clk         (clk_sys),
    .reset       (reset),
    .addr        (a_addr),
    .din         (a_din),
    .rd          (a_rd),
    .wr          (a_wr),
    .act         (act),
    .go          (go),
    .grant       (start & ~pick_b),
    .done_rd     (fill_ok & ~sel_b),
    .done_wr     (acc_wr & ~sel_b),
    .inval       (acc_wr),
    .inval_waddr (DDRAM_ADDR),
    .fill        (DDRAM_DOUT),
    .need        (need_a),
    .req         (req_a),
    .ready       (a_ready),
    .dout        (a_dout)
  );

  ddram_arb_port #(.AW(AW_B), .BASE(BASE_B)) u_b (
    .clk         (clk_sys),
    .reset       (reset),
    .addr        (b_addr),
    .din         (b_din),
    .rd          (b_rd),
    .wr          (b_wr),
    .act         (act),
    .go          (go),
    .grant       (start & pick_b),
    .done_rd     (fill_ok & sel_b),
    .done_wr     (acc_wr & sel_b),
    .inval       (acc_wr),
    .inval_waddr (DDRAM_ADDR),
    .fill        (DDRAM_DOUT),
    .need        (need_b),
    .req         (req_b),
    .ready       (b_ready),
    .dout        (b_dout)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= DRAIN;
      cnt        <= '0;
      last_b     <= 1'b1;
      sel_b      <= 1'b0;
      DDRAM_RD   <= 1'b0;
      DDRAM_WE   <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN  <= '0;
      DDRAM_BE   <= '0;
    end else begin
      unique case (state)
        DRAIN: begin
          cnt <= cnt + 1'b1;
          if (go)
            state <= IDLE;
        end
        IDLE: begin
          if (start) begin
            sel_b      <= pick_b;
            last_b     <= pick_b;
            DDRAM_ADDR <= greq.waddr;
            DDRAM_DIN  <= {8{greq.data}};
            DDRAM_BE   <= greq.we ? (8'd1 << greq.lane) : 8'hFF;
            DDRAM_WE   <= greq.we;
            DDRAM_RD   <= ~greq.we;
            state      <= greq.we ? ISSUE_WR : ISSUE_RD;
          end
        end
        ISSUE_RD: begin
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state    <= WAIT_RD;
          end
        end
        WAIT_RD: begin
          if (DDRAM_DOUT_READY)
            state <= IDLE;
        end
        ISSUE_WR: begin
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ddram_arb.sv
// Bench for ddram_arb: DDR responder model, golden byte memory,
// vector table plus hand-written arbitration/busy/coherency sequences.
module tb_ddram_arb;
  localparam logic [28:0] BA = 29'h0300000;
  // B window overlaps A so aliasing can be exercised
  localparam logic [28:0] BB = 29'h0300100;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic [20:0] a_addr = '0;
  logic [7:0]  a_din = '0;
  logic [7:0]  a_dout;
  logic        a_rd = 1'b0, a_wr = 1'b0, a_ready;
  logic [24:0] b_addr = '0;
  logic [7:0]  b_din = '0;
  logic [7:0]  b_dout;
  logic        b_rd = 1'b0, b_wr = 1'b0, b_ready;
  logic        DDRAM_BUSY = 1'b0;
  logic [28:0] DDRAM_ADDR;
  logic [7:0]  DDRAM_BURSTCNT;
  logic        DDRAM_RD, DDRAM_WE;
  logic [63:0] DDRAM_DIN;
  logic [7:0]  DDRAM_BE;
  logic [63:0] DDRAM_DOUT = '0;
  logic        DDRAM_DOUT_READY = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ddram_arb #(.BASE_A(BA), .BASE_B(BB)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .a_rd(a_rd), .a_wr(a_wr), .a_ready(a_ready),
    .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
    .b_rd(b_rd), .b_wr(b_wr), .b_ready(b_ready),
    .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_ADDR(DDRAM_ADDR),
    .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD),
    .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE),
    .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
  );

  // ---------------- DDR responder model ----------------
  logic [63:0] mem  [logic [28:0]];
  logic [63:0] gold [logic [28:0]];
  int   cyc = 0;
  int   rd_cnt = 0, we_cnt = 0, rd_hi = 0, we_hi = 0, addr_chg = 0;
  int   busy_n = 0, busy_run = 0, resp_cnt = 0;
  bit   inject = 0, rd_prev = 0;
  logic [63:0] resp_data, m;
  logic [28:0] rd_addr0;
  logic [28:0] wlog_addr[$];
  int          wlog_cyc[$];
  logic [7:0]  last_be;
  logic [63:0] last_din;

  function automatic logic [63:0] dflt(input logic [28:0] w);
    return {8{w[7:0]}} ^ 64'h0706050403020100;
  endfunction

  function automatic logic [63:0] rdmem(input logic [28:0] w);
    return mem.exists(w) ? mem[w] : dflt(w);
  endfunction

  always @(posedge clk_sys) cyc++;

  always @(negedge clk_sys) begin
    DDRAM_DOUT_READY = 1'b0;
    if (inject) begin
      DDRAM_DOUT_READY = 1'b1;
      DDRAM_DOUT = 64'hDEADBEEFCAFEF00D;
    end
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = resp_data;
      end
    end
    DDRAM_BUSY = DDRAM_RD && (busy_run < busy_n);
    if (DDRAM_RD) begin
      busy_run++;
      rd_hi++;
      if (rd_prev && DDRAM_ADDR != rd_addr0) addr_chg++;
      rd_addr0 = DDRAM_ADDR;
    end else begin
      busy_run = 0;
    end
    rd_prev = DDRAM_RD;
    if (DDRAM_RD && !DDRAM_BUSY) begin
      rd_cnt++;
      resp_data = rdmem(DDRAM_ADDR);
      resp_cnt = 3;
    end
    if (DDRAM_WE) we_hi++;
    if (DDRAM_WE && !DDRAM_BUSY) begin
      m = rdmem(DDRAM_ADDR);
      for (int i = 0; i < 8; i++)
        if (DDRAM_BE[i]) m[8*i +: 8] = DDRAM_DIN[8*i +: 8];
      mem[DDRAM_ADDR] = m;
      we_cnt++;
      wlog_addr.push_back(DDRAM_ADDR);
      wlog_cyc.push_back(cyc);
      last_be = DDRAM_BE;
      last_din = DDRAM_DIN;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gold_get(input logic [28:0] w,
                                          input logic [2:0] l);
    logic [63:0] v;
    v = gold.exists(w) ? gold[w] : dflt(w);
    return v[{l, 3'b000} +: 8];
  endfunction

  task automatic gold_set(input logic [28:0] w, input logic [2:0] l,
                          input logic [7:0] d);
    logic [63:0] v;
    v = gold.exists(w) ? gold[w] : dflt(w);
    v[{l, 3'b000} +: 8] = d;
    gold[w] = v;
  endtask

  function automatic logic [28:0] waddr_of(input int p,
                                           input logic [24:0] ad);
    return (p == 0) ? BA + 29'(ad[20:3]) : BB + 29'(ad[24:3]);
  endfunction

  function automatic logic rdy(input int p);
    return (p == 0) ? a_ready : b_ready;
  endfunction

  function automatic logic [7:0] dout_of(input int p);
    return (p == 0) ? a_dout : b_dout;
  endfunction

  task automatic raise(input int p, input logic [24:0] ad,
                       input logic w, input logic [7:0] d);
    if (p == 0) begin
      a_addr = ad[20:0]; a_din = d; a_wr = w; a_rd = ~w;
    end else begin
      b_addr = ad; b_din = d; b_wr = w; b_rd = ~w;
    end
    if (w) gold_set(waddr_of(p, ad), ad[2:0], d);
  endtask

  // called right after a negedge on which the request was raised
  task automatic wait_ready(input int p, output int n, output bit dropped);
    n = 0;
    dropped = 0;
    forever begin
      @(negedge clk_sys);
      n++;
      if (n == 1) begin
        dropped = !rdy(p);
        a_rd = 0; a_wr = 0; b_rd = 0; b_wr = 0;
      end
      if (n > 1 && rdy(p)) break;
      if (n >= 300) begin
        chk($sformatf("timeout_p%0d", p), 64'(rdy(p)), 64'd1);
        break;
      end
    end
  endtask

  logic [7:0] expq[$];

  task automatic xact(input string nm, input int p, input logic [24:0] ad,
                      input logic w, input logic [7:0] d, input int hit);
    int r0, w0, n;
    bit dr;
    logic [7:0] e;
    r0 = rd_cnt;
    w0 = we_cnt;
    if (!w) expq.push_back(gold_get(waddr_of(p, ad), ad[2:0]));
    raise(p, ad, w, d);
    wait_ready(p, n, dr);
    chk({nm, "_drop"}, 64'(dr), 64'd1);
    if (w) begin
      chk({nm, "_wecnt"}, 64'(we_cnt - w0), 64'd1);
    end else begin
      e = expq.pop_front();
      chk({nm, "_data"}, 64'(dout_of(p)), 64'(e));
      chk({nm, "_rdcnt"}, 64'(rd_cnt - r0), (hit != 0) ? 64'd0 : 64'd1);
      if (hit != 0) chk({nm, "_lat"}, 64'(n), 64'd2);
    end
  endtask

  typedef struct {
    int          p;
    logic        w;
    logic [24:0] ad;
    logic [7:0]  d;
    int          hit;
  } vec_t;

  vec_t tv[14];

  initial begin
    int n, k, we0, rh0, ac0;
    bit dr;

    tv[0]  = '{0, 1'b0, 25'h0000000, 8'h00, 0};
    tv[1]  = '{0, 1'b0, 25'h0000003, 8'h00, 1};
    tv[2]  = '{0, 1'b0, 25'h0000005, 8'h00, 1};
    tv[3]  = '{0, 1'b0, 25'h0000008, 8'h00, 0};
    tv[4]  = '{1, 1'b0, 25'h0000010, 8'h00, 0};
    tv[5]  = '{1, 1'b0, 25'h0000017, 8'h00, 1};
    tv[6]  = '{0, 1'b1, 25'h0000002, 8'hEE, 0};
    tv[7]  = '{0, 1'b0, 25'h0000002, 8'h00, 0};
    tv[8]  = '{0, 1'b1, 25'h0000003, 8'h77, 0};
    tv[9]  = '{0, 1'b0, 25'h0000003, 8'h00, 1};
    tv[10] = '{1, 1'b1, 25'h0000011, 8'h99, 0};
    tv[11] = '{1, 1'b0, 25'h0000011, 8'h00, 1};
    tv[12] = '{0, 1'b0, 25'h01FFFFF, 8'h00, 0};
    tv[13] = '{1, 1'b0, 25'h1FFFFFF, 8'h00, 0};

    // reset and drain window, with stray read data injected
    repeat (3) @(negedge clk_sys);
    chk("rst_rd", 64'(DDRAM_RD), 64'd0);
    chk("rst_we", 64'(DDRAM_WE), 64'd0);
    chk("rst_addr", 64'(DDRAM_ADDR), 64'd0);
    chk("rst_ready_a", 64'(a_ready), 64'd0);
    chk("burstcnt", 64'(DDRAM_BURSTCNT), 64'd1);
    inject = 1;
    reset = 1'b0;
    repeat (63) @(posedge clk_sys);
    #1;
    chk("drain_ready_a", 64'(a_ready), 64'd0);
    chk("drain_ready_b", 64'(b_ready), 64'd0);
    @(posedge clk_sys);
    #1;
    chk("post_drain_ready_a", 64'(a_ready), 64'd1);
    chk("post_drain_ready_b", 64'(b_ready), 64'd1);
    inject = 0;
    @(negedge clk_sys);
    chk("drain_no_cmd", 64'(rd_cnt + we_cnt), 64'd0);

    // single posted write
    we0 = we_hi;
    xact("wr5", 0, 25'h5, 1'b1, 8'h5A, 0);
    chk("wr5_addr", 64'(wlog_addr[$]), 64'(BA));
    chk("wr5_be", 64'(last_be), 64'h20);
    chk("wr5_din", last_din, 64'h5A5A5A5A5A5A5A5A);
    chk("wr5_we_cycles", 64'(we_hi - we0), 64'd1);

    for (int i = 0; i < 14; i++)
      xact($sformatf("v%0d", i), tv[i].p, tv[i].ad, tv[i].w,
           tv[i].d, tv[i].hit);

    // last grant was B: A goes first, B issued right after
    @(negedge clk_sys);
    k = wlog_addr.size();
    raise(0, 25'h40, 1'b1, 8'h11);
    raise(1, 25'h40, 1'b1, 8'h22);
    wait_ready(0, n, dr);
    wait_ready(1, n, dr);
    chk("arb1_size", 64'(wlog_addr.size() - k), 64'd2);
    if (wlog_addr.size() >= k + 2) begin
      chk("arb1_first", 64'(wlog_addr[k]), 64'(BA + 29'h8));
      chk("arb1_second", 64'(wlog_addr[k+1]), 64'(BB + 29'h8));
      chk("arb1_gap", 64'(wlog_cyc[k+1] - wlog_cyc[k]), 64'd2);
    end

    // now last grant was B again; a B-granted round flips to A-first
    @(negedge clk_sys);
    k = wlog_addr.size();
    raise(1, 25'h48, 1'b1, 8'h33);
    wait_ready(1, n, dr);
    raise(0, 25'h50, 1'b1, 8'h44);
    raise(1, 25'h50, 1'b1, 8'h55);
    wait_ready(0, n, dr);
    wait_ready(1, n, dr);
    chk("arb2_size", 64'(wlog_addr.size() - k), 64'd3);
    if (wlog_addr.size() >= k + 3)
      chk("arb2_first", 64'(wlog_addr[k+1]), 64'(BA + 29'hA));

    // DDRAM_BUSY held across a read issue
    busy_n = 10;
    rh0 = rd_hi;
    ac0 = addr_chg;
    xact("busy_rd", 0, 25'h20, 1'b0, 8'h00, 0);
    chk("busy_rd_hi", 64'(rd_hi - rh0), 64'd11);
    chk("busy_addr_stable", 64'(addr_chg - ac0), 64'd0);
    busy_n = 0;

    // cross-port coherency through aliased windows
    xact("coh_fill", 0, 25'h803, 1'b0, 8'h00, 0);
    xact("coh_hit", 0, 25'h801, 1'b0, 8'h00, 1);
    xact("coh_bwr", 1, 25'h003, 1'b1, 8'hC3, 0);
    xact("coh_miss", 0, 25'h803, 1'b0, 8'h00, 0);
    chk("coh_val", 64'(a_dout), 64'hC3);

    // reads of words last written by the arbitration rounds
    xact("arb_rb_a", 0, 25'h50, 1'b0, 8'h00, 0);
    xact("arb_rb_b", 1, 25'h50, 1'b0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
